// File: rtl/cntry_car_detect.sv
// Country-road car detector: synchronizes and debounces the loop sensor, then keeps a
// saturating queue count that drains one car per DEPART_CYCLES cycles of country green.
module cntry_car_detect #(
  parameter int unsigned DEBOUNCE      = 3,
  parameter int unsigned DEPART_CYCLES = 4
) (
  input  logic       clock,
  input  logic       clear,
  input  logic       loop_in,
  input  logic [1:0] cntry,
  output logic       X,
  output logic [3:0] car_count,
  output logic       overflow
);

  typedef enum logic [1:0] {
    StLow,
    StChkHigh,
    StHigh,
    StChkLow
  } db_state_e;

  localparam logic [3:0] DebLim   = 4'(DEBOUNCE);
  localparam logic [3:0] DepLim   = 4'(DEPART_CYCLES - 1);
  localparam logic [1:0] CntGreen = 2'd2;
  localparam logic [3:0] CountMax = 4'd15;

  logic       s1_q, s2_q;
  db_state_e  state_q, state_d;
  logic [3:0] stab_q, stab_d;
  logic [3:0] timer_q, timer_d;
  logic [3:0] count_q, count_d;
  logic       x_q, x_d;
  logic       ovf_q, ovf_d;

  logic       arrival;
  logic       green_active;
  logic       depart;

  // Debouncer: a level change is accepted only after the stability counter reaches its limit.
  always_comb begin
    state_d = state_q;
    stab_d  = stab_q;
    arrival = 1'b0;
    unique case (state_q)
      StLow: begin
        if (s2_q) begin
          state_d = StChkHigh;
          stab_d  = 4'd1;
        end else begin
          stab_d = 4'd0;
        end
      end
      StChkHigh: begin
        if (!s2_q) begin
          state_d = StLow;
          stab_d  = 4'd0;
        end else if (stab_q == DebLim) begin
          state_d = StHigh;
          stab_d  = 4'd0;
          arrival = 1'b1;
        end else begin
          stab_d = stab_q + 4'd1;
        end
      end
      StHigh: begin
        if (!s2_q) begin
          state_d = StChkLow;
          stab_d  = 4'd1;
        end else begin
          stab_d = 4'd0;
        end
      end
      StChkLow: begin
        if (s2_q) begin
          state_d = StHigh;
          stab_d  = 4'd0;
        end else if (stab_q == DebLim) begin
          state_d = StLow;
          stab_d  = 4'd0;
        end else begin
          stab_d = stab_q + 4'd1;
        end
      end
      default: begin
        state_d = StLow;
        stab_d  = 4'd0;
      end
    endcase
  end

  // Departure timer only runs through an uninterrupted green with cars waiting.
  always_comb begin
    green_active = (cntry == CntGreen) && (count_q != 4'd0);
    depart       = green_active && (timer_q == DepLim);
    timer_d      = (green_active && !depart) ? timer_q + 4'd1 : 4'd0;
  end

  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    if (arrival && !depart) begin
      if (count_q == CountMax) begin
        ovf_d = 1'b1;
      end else begin
        count_d = count_q + 4'd1;
      end
    end else if (depart && !arrival) begin
      count_d = count_q - 4'd1;
    end
    x_d = (count_d != 4'd0);
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      state_q <= StLow;
      stab_q  <= 4'd0;
      timer_q <= 4'd0;
      count_q <= 4'd0;
      x_q     <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      s1_q    <= loop_in;
      s2_q    <= s1_q;
      state_q <= state_d;
      stab_q  <= stab_d;
      timer_q <= timer_d;
      count_q <= count_d;
      x_q     <= x_d;
      ovf_q   <= ovf_d;
    end
  end

  assign X         = x_q;
  assign car_count = count_q;
  assign overflow  = ovf_q;

endmodule

// File: doc/cntry_car_detect.md
CNTRY_CAR_DETECT -- requirements
Module: cntry_car_detect

Interface
REQ-001 Parameter DEBOUNCE, default 3, is the number of consecutive stable synchronized samples needed to accept a loop level change (legal 1..15).
REQ-002 Parameter DEPART_CYCLES, default 4, is the number of country-green cycles per released car (legal 1..15).
REQ-003 clock  input  1  single clock for the block; all state changes on its rising edge.
REQ-004 clear  input  1  reset, asynchronous and active-high.
REQ-005 loop_in  input  1  raw country-road loop sensor; asynchronous to clock, may bounce.
REQ-006 cntry  input  2  country-road signal from sig_control: 2'd0 RED, 2'd1 YELLOW, 2'd2 GREEN.
REQ-007 X  output  1  car-on-country-road request to sig_control; registered.
REQ-008 car_count  output  4  number of cars queued on the country road; registered.
REQ-009 overflow  output  1  sticky flag: an arrival was lost at a full queue; registered.

Function
REQ-010 loop_in SHALL pass through a two-flop synchronizer (s1, s2) before any other use.
REQ-011 The debouncer SHALL be a four-state FSM: LOW, CHK_HIGH, HIGH, CHK_LOW, with a 4-bit stability counter.
- LOW: s2=1 -> CHK_HIGH, counter=1.
- CHK_HIGH: s2=0 -> LOW; s2=1 and counter=DEBOUNCE -> HIGH plus one-cycle arrival pulse; otherwise counter+1.
- HIGH and CHK_LOW: mirror images of LOW and CHK_HIGH, with no pulse on entering LOW.
REQ-012 A loop_in high held steady from its first sampling edge n SHALL increment car_count at edge n+DEBOUNCE+2 (edge n+5 by default).
REQ-013 A high glitch shorter than DEBOUNCE synchronized samples SHALL produce no arrival.
REQ-014 A 4-bit departure timer SHALL advance only while cntry==2'd2 and car_count!=0.
- The timer SHALL clear to 0 on any cycle where cntry!=2'd2 or car_count==0.
REQ-015 When the timer equals DEPART_CYCLES-1 with cntry==2'd2 and car_count!=0, a departure event SHALL occur and the timer SHALL return to 0.
- Consequence: the first departure lands on the DEPART_CYCLES-th consecutive green edge.
REQ-016 Count update rules:
- arrival only: car_count+1;
- departure only: car_count-1;
- arrival and departure on the same edge: unchanged.
REQ-017 At car_count==15:
- an arrival without a departure SHALL leave car_count at 15 and set overflow;
- overflow SHALL stay set until clear.
REQ-018 car_count SHALL never decrement below 0; departures are impossible at 0 by REQ-014.
REQ-019 X SHALL be registered as (next car_count != 0), so X and car_count change on the same edge.
REQ-020 cntry==2'd1 (YELLOW) and cntry==2'd3 (illegal) SHALL be treated as not-green.
REQ-021 A departure interrupted by green ending SHALL NOT occur; the partial timer count is discarded.

Reset
REQ-022 While clear=1, all of the following SHALL hold immediately, without waiting for a clock edge: s1=s2=0, FSM=LOW, stability counter=0, departure timer=0, car_count=0, X=0, overflow=0.
REQ-023 clear asserted mid-debounce or mid-departure SHALL abandon the operation; no arrival or departure SHALL be generated on release.
REQ-024 A loop_in already high at clear release SHALL be counted as one arrival after the normal debounce latency.

Verification
REQ-025 Default parameters, cntry=RED, loop_in 0->1 held:
- car_count=1 and X=1 at the 5th edge after first sampling;
- no further count while held.
REQ-026 loop_in high pulses lasting 1 and 2 cycles -> car_count stays 0, X stays 0.
REQ-027 Three clean arrivals, then cntry=GREEN held:
- car_count steps 3->2->1->0 at green edges 4, 8 and 12;
- X falls with the last step.
REQ-028 Sixteen clean arrivals with cntry=RED -> car_count=15, overflow=1, X=1; overflow persists after later departures.
REQ-029 Arrival pulse coincident with a departure edge (car_count=2, green) -> car_count stays 2.
REQ-030 Count of 2, green for 3 cycles, then YELLOW:
- no departure occurs;
- the next green needs 4 full cycles before the first departure.
- Separately, asserting clear asynchronously mid-debounce -> all outputs 0 before the next edge.
